pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_pkg.sv | 10 +
 rtl/sat_counter.sv | 25 ++
 rtl/pipe_reg.sv | 115 +++++++++++
 tb/tb_pipe_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults for the pipeline stage register: field widths and the
// all-zero fill value used when a bubble is loaded.
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_A_W    = 5;
  localparam int DEF_TNEW_W = 3;
  localparam int DEF_CNT_W  = 32;

  localparam logic BUBBLE_FILL = 1'b0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and bubble statistics.
// It holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q = '0;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipe_reg.sv
// One pipeline stage register with stall/flush, Tnew ageing and a
// combinational forwarding-ready flag. There is no backpressure: in_valid
// only qualifies in_a3/in_tnew; stall holds the stage, flush loads a bubble.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int A_W      = DEF_A_W,
  parameter int TNEW_W   = DEF_TNEW_W,
  parameter int DEC_TNEW = 1,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [A_W-1:0]         in_a3,
  input  logic [TNEW_W-1:0]      in_tnew,
  output logic                   out_valid,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [A_W-1:0]         out_a3,
  output logic [TNEW_W-1:0]      out_tnew,
  output logic                   out_fwd_ok,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);
  logic              valid_q = 1'b0;
  logic [A_W-1:0]    a3_q    = '0;
  logic [TNEW_W-1:0] tnew_q  = '0;
  logic              valid_d;
  logic [A_W-1:0]    a3_d;
  logic [TNEW_W-1:0] tnew_d;
  logic [TNEW_W-1:0] tnew_load;
  logic              load_en;
  logic              bubble_load;
  logic              stall_inc;

  // Flush wins over stall; a plain load happens only when neither is set.
  assign load_en     = !flush && !stall;
  assign bubble_load = flush || (load_en && !in_valid);
  assign stall_inc   = stall && !flush;

  always_comb begin
    tnew_load = in_tnew;
    if (DEC_TNEW != 0) tnew_load = (in_tnew != '0) ? in_tnew - TNEW_W'(1) : '0;
  end

  always_comb begin
    valid_d = valid_q;
    a3_d    = a3_q;
    tnew_d  = tnew_q;
    if (bubble_load) begin
      valid_d = 1'b0;
      a3_d    = {A_W{BUBBLE_FILL}};
      tnew_d  = {TNEW_W{BUBBLE_FILL}};
    end else if (load_en) begin
      valid_d = 1'b1;
      a3_d    = in_a3;
      tnew_d  = tnew_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a3_q    <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DATA_W-1:0] word_q = '0;
    logic [DATA_W-1:0] word_d;

    // A bubble from a plain load keeps the payload; only flush zeroes it.
    always_comb begin
      word_d = word_q;
      if (flush)        word_d = {DATA_W{BUBBLE_FILL}};
      else if (load_en) word_d = in_data[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
      if (rst) word_q <= '0;
      else     word_q <= word_d;
    end

    assign out_data[k*DATA_W +: DATA_W] = word_q;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_load),
    .count (bubble_cnt)
  );

  assign out_valid  = valid_q;
  assign out_a3     = a3_q;
  assign out_tnew   = tnew_q;
  assign out_fwd_ok = valid_q && (tnew_q == '0) && (a3_q != '0);
endmodule

// File: tb/tb_pipe_reg.sv
// Drives a default stage and a narrow (N_CH=1, DATA_W=16, DEC_TNEW=0, CNT_W=2)
// stage with the same controls and compares both against a rule-level model.
module tb_pipe_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, stall, flush, in_valid;
  logic [127:0] in_data;
  logic [4:0]   in_a3;
  logic [2:0]   in_tnew;

  logic         out_valid_a, fwd_a;
  logic [127:0] out_data_a;
  logic [4:0]   out_a3_a;
  logic [2:0]   out_tnew_a;
  logic [31:0]  stall_cnt_a, bubble_cnt_a;

  logic         out_valid_b, fwd_b;
  logic [15:0]  out_data_b;
  logic [4:0]   out_a3_b;
  logic [2:0]   out_tnew_b;
  logic [1:0]   stall_cnt_b, bubble_cnt_b;

  pipe_reg dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_a3(in_a3), .in_tnew(in_tnew),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_a3(out_a3_a),
    .out_tnew(out_tnew_a), .out_fwd_ok(fwd_a),
    .stall_cnt(stall_cnt_a), .bubble_cnt(bubble_cnt_a)
  );

  pipe_reg #(.N_CH(1), .DATA_W(16), .DEC_TNEW(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data[15:0]), .in_a3(in_a3), .in_tnew(in_tnew),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_a3(out_a3_b),
    .out_tnew(out_tnew_b), .out_fwd_ok(fwd_b),
    .stall_cnt(stall_cnt_b), .bubble_cnt(bubble_cnt_b)
  );

  // Reference state: what each stage should hold after the latest edge.
  logic         m_valid_a = 0, m_valid_b = 0;
  logic [127:0] m_data_a = '0;
  logic [15:0]  m_data_b = '0;
  logic [4:0]   m_a3_a = '0, m_a3_b = '0;
  logic [2:0]   m_tnew_a = '0, m_tnew_b = '0;
  int unsigned  m_stall_a = 0, m_bubble_a = 0, m_stall_b = 0, m_bubble_b = 0;

  int unsigned pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the stage rules to the inputs sampled at this edge.
  task automatic model_edge();
    int t;
    if (rst) begin
      m_valid_a = 0; m_data_a = '0; m_a3_a = '0; m_tnew_a = '0; m_stall_a = 0; m_bubble_a = 0;
      m_valid_b = 0; m_data_b = '0; m_a3_b = '0; m_tnew_b = '0; m_stall_b = 0; m_bubble_b = 0;
    end else if (flush) begin
      m_valid_a = 0; m_data_a = '0; m_a3_a = '0; m_tnew_a = '0;
      m_valid_b = 0; m_data_b = '0; m_a3_b = '0; m_tnew_b = '0;
      m_bubble_a = (m_bubble_a == 32'hFFFF_FFFF) ? m_bubble_a : m_bubble_a + 1;
      m_bubble_b = (m_bubble_b == 3) ? 3 : m_bubble_b + 1;
    end else if (stall) begin
      m_stall_a = (m_stall_a == 32'hFFFF_FFFF) ? m_stall_a : m_stall_a + 1;
      m_stall_b = (m_stall_b == 3) ? 3 : m_stall_b + 1;
    end else begin
      m_data_a = in_data;
      m_data_b = in_data[15:0];
      if (in_valid) begin
        t = int'(in_tnew) - 1;
        m_valid_a = 1; m_a3_a = in_a3; m_tnew_a = (t < 0) ? 3'd0 : 3'(t);
        m_valid_b = 1; m_a3_b = in_a3; m_tnew_b = in_tnew;
      end else begin
        m_valid_a = 0; m_a3_a = '0; m_tnew_a = '0;
        m_valid_b = 0; m_a3_b = '0; m_tnew_b = '0;
        m_bubble_a = (m_bubble_a == 32'hFFFF_FFFF) ? m_bubble_a : m_bubble_a + 1;
        m_bubble_b = (m_bubble_b == 3) ? 3 : m_bubble_b + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a.valid"},  128'(out_valid_a),  128'(m_valid_a));
    chk({tag, ".a.data"},   out_data_a,         m_data_a);
    chk({tag, ".a.a3"},     128'(out_a3_a),     128'(m_a3_a));
    chk({tag, ".a.tnew"},   128'(out_tnew_a),   128'(m_tnew_a));
    chk({tag, ".a.fwd"},    128'(fwd_a),        128'(m_valid_a && m_tnew_a == 0 && m_a3_a != 0));
    chk({tag, ".a.stalls"}, 128'(stall_cnt_a),  128'(m_stall_a));
    chk({tag, ".a.bubbles"},128'(bubble_cnt_a), 128'(m_bubble_a));
    chk({tag, ".b.valid"},  128'(out_valid_b),  128'(m_valid_b));
    chk({tag, ".b.data"},   128'(out_data_b),   128'(m_data_b));
    chk({tag, ".b.a3"},     128'(out_a3_b),     128'(m_a3_b));
    chk({tag, ".b.tnew"},   128'(out_tnew_b),   128'(m_tnew_b));
    chk({tag, ".b.fwd"},    128'(fwd_b),        128'(m_valid_b && m_tnew_b == 0 && m_a3_b != 0));
    chk({tag, ".b.stalls"}, 128'(stall_cnt_b),  128'(m_stall_b));
    chk({tag, ".b.bubbles"},128'(bubble_cnt_b), 128'(m_bubble_b));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  logic [1:0] sat_tbl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  int unsigned bub_before;

  initial begin
    rst = 0; stall = 0; flush = 0; in_valid = 0; in_data = '0; in_a3 = '0; in_tnew = '0;
    #1;
    check_all("powerup");

    rst = 1; cycle("reset"); rst = 0;

    // Basic load with Tnew ageing
    rand_data(); in_data[31:0] = 32'h0000_3000;
    in_valid = 1; in_a3 = 5'd8; in_tnew = 3'd2;
    cycle("load1");
    chk("load1.tnew", 128'(out_tnew_a), 128'(1));
    chk("load1.word0", 128'(out_data_a[31:0]), 128'h3000);
    chk("load1.fwd", 128'(fwd_a), 128'(0));

    in_tnew = 3'd0; rand_data();
    cycle("fwd_ready");
    chk("fwd_ready.fwd", 128'(fwd_a), 128'(1));
    in_a3 = 5'd0;
    cycle("fwd_r0");
    chk("fwd_r0.fwd", 128'(fwd_a), 128'(0));

    // Stall holds everything, including Tnew
    in_a3 = 5'd8; in_tnew = 3'd2; rand_data();
    cycle("pre_stall");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_data(); in_tnew = 3'($urandom_range(0, 7));
      cycle("stall");
    end
    chk("stall.count", 128'(stall_cnt_a), 128'(3));
    chk("stall.tnew", 128'(out_tnew_a), 128'(1));

    // Stall and flush together count only as a bubble
    bub_before = bubble_cnt_a;
    flush = 1;
    cycle("stall_flush");
    chk("stall_flush.bubbles", 128'(bubble_cnt_a), 128'(bub_before + 1));
    chk("stall_flush.stalls", 128'(stall_cnt_a), 128'(3));
    chk("stall_flush.data", out_data_a, 128'(0));
    stall = 0; flush = 0;

    // Pass-through Tnew on the narrow instance
    in_valid = 1; in_tnew = 3'd3; in_a3 = 5'd9; rand_data();
    cycle("tnew_pass");
    chk("tnew_pass.b", 128'(out_tnew_b), 128'(3));
    chk("tnew_pass.a", 128'(out_tnew_a), 128'(2));

    // Reset while stalled, then normal load
    stall = 1; rst = 1; cycle("rst_stalled");
    rst = 0; stall = 0; rand_data(); in_tnew = 3'd0;
    cycle("after_rst");

    // Narrow counter saturation, then reset clears it
    rst = 1; cycle("rst2"); rst = 0;
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      cycle("sat");
      chk($sformatf("sat.step%0d", i), 128'(stall_cnt_b), 128'(sat_tbl[i]));
    end
    stall = 0; rst = 1;
    cycle("rst3");
    chk("rst3.stalls", 128'(stall_cnt_b), 128'(0));
    rst = 0;

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_a3    = 5'($urandom_range(0, 31));
      in_tnew  = 3'($urandom_range(0, 7));
      rand_data();
      cycle("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
